// File: rtl/mem_dump_unit_pkg.sv
// Shared definitions for the memory dump unit: FSM encoding, MEM access size codes
// and the word geometry used by the byte serializer.
package mem_dump_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  typedef enum logic [2:0] {
    BHW_SB  = 3'b000,
    BHW_SH  = 3'b001,
    BHW_LW  = 3'b011,
    BHW_LBU = 3'b100,
    BHW_LHU = 3'b101,
    BHW_LWU = 3'b111
  } bhw_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/mem_dump_serializer.sv
// Splits one loaded word into bytes, MSB first, over a valid/ready handshake.
// A byte is held stable until accepted; o_word_done pulses as the last byte is taken.
module mem_dump_serializer
  import mem_dump_unit_pkg::*;
#(
  parameter int NB_WIDTH = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic [NB_WIDTH-1:0] i_word,
  input  logic                i_tx_ready,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_valid,
  output logic                o_word_done
);

  localparam int NB_IDX = $clog2(BYTES_PER_WORD);
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(BYTES_PER_WORD - 1);

  logic [NB_WIDTH-1:0] shift;
  logic [NB_IDX-1:0]   byte_idx;
  logic                accept;

  assign accept      = o_tx_valid & i_tx_ready;
  assign o_tx_data   = shift[NB_WIDTH-1 -: NB_BYTE];
  assign o_word_done = accept && (byte_idx == LAST_IDX);

  // Clear wins over load so an abort during the fetch discards the word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift      <= '0;
      byte_idx   <= '0;
      o_tx_valid <= 1'b0;
    end else if (i_clear) begin
      shift      <= '0;
      byte_idx   <= '0;
      o_tx_valid <= 1'b0;
    end else if (i_load) begin
      shift      <= i_word;
      byte_idx   <= '0;
      o_tx_valid <= 1'b1;
    end else if (accept) begin
      shift    <= shift << NB_BYTE;
      byte_idx <= byte_idx + 1'b1;
      if (byte_idx == LAST_IDX) o_tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_dump_unit.sv
// Reads a run of aligned words from data memory and streams them byte-wise to a UART.
// Six cycles per word at full ready; a stalled transmitter holds the current byte.
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9,
  parameter int NB_BYTE  = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [NB_ADDR-1:0]  i_first_addr,
  input  logic [NB_ADDR-2:0]  i_word_count,
  output logic [NB_WIDTH-1:0] o_mem_addr,
  output logic                o_mem_read,
  output logic [2:0]          o_BHW,
  input  logic [NB_WIDTH-1:0] i_read_data,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [NB_ADDR-1:0] WORD_STRIDE = NB_ADDR'(BYTES_PER_WORD);
  localparam logic [NB_ADDR-2:0] ONE_WORD    = (NB_ADDR-1)'(1);

  dump_state_t        state;
  logic [NB_ADDR-1:0] addr;
  logic [NB_ADDR-2:0] remaining;
  logic [NB_ADDR-1:0] start_addr;
  logic [NB_ADDR-1:0] next_addr;
  logic               word_done;

  assign o_BHW      = BHW_LW;
  assign start_addr = {i_first_addr[NB_ADDR-1:2], 2'b00};
  assign next_addr  = addr + WORD_STRIDE;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      remaining  <= '0;
      o_mem_addr <= '0;
      o_mem_read <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_mem_read <= 1'b0;
      o_done     <= 1'b0;
      if (i_abort) begin
        state  <= ST_IDLE;
        o_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              o_busy <= 1'b1;
              if (i_word_count == '0) begin
                state  <= ST_DONE;
                o_done <= 1'b1;
              end else begin
                addr       <= start_addr;
                remaining  <= i_word_count;
                o_mem_read <= 1'b1;
                o_mem_addr <= NB_WIDTH'(start_addr);
                state      <= ST_REQ;
              end
            end
          end
          ST_REQ:  state <= ST_WAIT;
          ST_WAIT: state <= ST_SEND;
          ST_SEND: begin
            if (word_done) begin
              if (remaining == ONE_WORD) begin
                state  <= ST_DONE;
                o_done <= 1'b1;
              end else begin
                // Address wraps naturally at the top of the byte-address space.
                addr       <= next_addr;
                remaining  <= remaining - ONE_WORD;
                o_mem_read <= 1'b1;
                o_mem_addr <= NB_WIDTH'(next_addr);
                state      <= ST_REQ;
              end
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  mem_dump_serializer #(
    .NB_WIDTH(NB_WIDTH),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (i_abort),
    .i_load     (state == ST_WAIT),
    .i_word     (i_read_data),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_word_done(word_done)
  );

endmodule

// File: tb/tb_mem_dump_unit.sv
// Randomized and directed checks of mem_dump_unit against a queue-based model of the dump.
module tb_mem_dump_unit;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_abort;
  logic [8:0]  i_first_addr;
  logic [7:0]  i_word_count;
  logic [31:0] o_mem_addr;
  logic        o_mem_read;
  logic [2:0]  o_BHW;
  logic [31:0] i_read_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;

  mem_dump_unit dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_first_addr(i_first_addr),
    .i_word_count(i_word_count),
    .o_mem_addr  (o_mem_addr),
    .o_mem_read  (o_mem_read),
    .o_BHW       (o_BHW),
    .i_read_data (i_read_data),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ready_mode = 0;

  logic [31:0] mem [128];
  int unsigned exp_addr[$];
  logic [7:0]  exp_bytes[$];
  int          done_pending = 0;

  logic [31:0] got_addrs[$];
  logic [7:0]  got_bytes[$];
  int first_req_cyc = -1;
  int done_cyc = -1;
  int start_cyc = 0;
  int vld_seen = 0;
  int stall_seen = 0;

  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic       prev_dist = 1'b1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Synchronous-read data memory: result appears the cycle after the strobe.
  always @(posedge i_clk) if (o_mem_read) i_read_data <= mem[o_mem_addr[8:2]];

  initial begin
    i_tx_ready = 1'b0;
    forever begin
      @(posedge i_clk); #2;
      case (ready_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = cyc[1];
        2:       i_tx_ready = 1'($urandom);
        default: i_tx_ready = 1'b0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (i_reset) begin
      prev_dist = 1'b1;
      prev_vld  = 1'b0;
    end else begin
      chk("bhw", 32'(o_BHW), 32'h3);
      if (!o_busy) chk("idle_quiet", {30'b0, o_mem_read, o_tx_valid}, 32'h0);
      if (o_mem_read) begin
        got_addrs.push_back(o_mem_addr);
        if (first_req_cyc < 0) first_req_cyc = cyc;
        chk("rd_expected", 32'(exp_addr.size() > 0), 32'h1);
        if (exp_addr.size() > 0) chk("rd_addr", o_mem_addr, exp_addr.pop_front());
      end
      if (o_tx_valid) vld_seen++;
      if (o_tx_valid && i_tx_ready) begin
        got_bytes.push_back(o_tx_data);
        chk("tx_expected", 32'(exp_bytes.size() > 0), 32'h1);
        if (exp_bytes.size() > 0) chk("tx_byte", 32'(o_tx_data), 32'(exp_bytes.pop_front()));
      end
      if (prev_vld && !prev_rdy && !prev_dist) begin
        stall_seen++;
        chk("hold_valid", 32'(o_tx_valid), 32'h1);
        chk("hold_data", 32'(o_tx_data), 32'(prev_dat));
      end
      if (o_done) begin
        done_cyc = cyc;
        chk("done_expected", 32'(done_pending > 0), 32'h1);
        chk("done_drained", exp_bytes.size(), 0);
        if (done_pending > 0) done_pending--;
      end
      prev_vld  = o_tx_valid;
      prev_rdy  = i_tx_ready;
      prev_dat  = o_tx_data;
      prev_dist = i_abort;
    end
  end

  task automatic clear_logs();
    got_addrs.delete();
    got_bytes.delete();
    first_req_cyc = -1;
    done_cyc = -1;
    vld_seen = 0;
    stall_seen = 0;
  endtask

  task automatic clear_model();
    exp_addr.delete();
    exp_bytes.delete();
    done_pending = 0;
  endtask

  // Model: n consecutive aligned words from the start address, mod 512, sent MSB byte first.
  task automatic start_dump(input logic [8:0] a, input int n);
    int unsigned wa;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      wa = ((int'(a) / 4) * 4 + 4 * i) % 512;
      exp_addr.push_back(wa);
      w = mem[wa / 4];
      for (int b = 3; b >= 0; b--) exp_bytes.push_back(w[8*b +: 8]);
    end
    done_pending++;
    i_first_addr = a;
    i_word_count = 8'(n);
    i_start = 1'b1;
    start_cyc = cyc;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit poke);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      if (poke) begin
        i_start      = ($urandom % 4 == 0);
        i_first_addr = 9'($urandom);
        i_word_count = 8'($urandom);
      end
      @(posedge i_clk); #1;
      n++;
    end
    i_start = 1'b0;
    chk("idle_reached", 32'(o_busy), 32'h0);
    if (o_busy) begin
      i_abort = 1'b1;
      @(posedge i_clk); #1;
      i_abort = 1'b0;
      clear_model();
    end
    chk("model_addr_drained", exp_addr.size(), 0);
    chk("model_bytes_drained", exp_bytes.size(), 0);
    chk("model_done_seen", done_pending, 0);
  endtask

  task automatic check_bytes(input string name, input logic [63:0] lit, input int n);
    chk({name, "_len"}, got_bytes.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_bytes.size()) chk(name, 32'(got_bytes[i]), 32'(lit[8*(n-1-i) +: 8]));
  endtask

  task automatic check_addrs(input string name, input logic [31:0] a0, input logic [31:0] a1, input int n);
    chk({name, "_len"}, got_addrs.size(), n);
    if (n > 0 && got_addrs.size() > 0) chk(name, got_addrs[0], a0);
    if (n > 1 && got_addrs.size() > 1) chk(name, got_addrs[1], a1);
  endtask

  task automatic outputs_zero(input string name, input bit with_addr);
    chk({name, "_mem_read"}, 32'(o_mem_read), 32'h0);
    chk({name, "_tx_valid"}, 32'(o_tx_valid), 32'h0);
    chk({name, "_busy"}, 32'(o_busy), 32'h0);
    chk({name, "_done"}, 32'(o_done), 32'h0);
    chk({name, "_tx_data"}, 32'(o_tx_data), 32'h0);
    if (with_addr) chk({name, "_mem_addr"}, o_mem_addr, 32'h0);
  endtask

  // Stall on the second byte of word 0x10, then disturb with abort (0) or reset (1).
  task automatic disturb_second_byte(input bit use_reset);
    int n;
    ready_mode = 3;
    clear_logs();
    start_dump(9'h010, 1);
    n = 0;
    while (!o_tx_valid && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("disturb_valid_seen", 32'(o_tx_valid), 32'h1);
    ready_mode = 0;
    @(posedge i_clk); #1;
    ready_mode = 3;
    #2;
    chk("disturb_second_byte", 32'(o_tx_data), 32'h34);
    clear_model();
    if (use_reset) begin
      i_reset = 1'b1;
      #1;
      outputs_zero("reset_mid", 1'b1);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
    end else begin
      i_abort = 1'b1;
      @(posedge i_clk); #1;
      i_abort = 1'b0;
      outputs_zero("abort_mid", 1'b0);
    end
    repeat (6) @(posedge i_clk);
    #1;
    chk("disturb_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    ready_mode = 0;
    clear_logs();
    start_dump(9'h010, 1);
    wait_idle(100, 1'b0);
    check_bytes(use_reset ? "after_reset" : "after_abort", 64'h12345678, 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_first_addr = '0;
    i_word_count = '0;
    ready_mode = 0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    #2;
    outputs_zero("reset", 1'b1);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    mem[4] = 32'h12345678;
    mem[5] = 32'hCAFEBABE;
    clear_logs();
    start_dump(9'h010, 2);
    wait_idle(200, 1'b0);
    check_bytes("two_word", 64'h12345678_CAFEBABE, 8);
    check_addrs("two_word_addr", 32'h010, 32'h014, 2);
    chk("two_word_latency", done_cyc - first_req_cyc, 12);

    clear_logs();
    start_dump(9'h013, 1);
    wait_idle(200, 1'b0);
    check_addrs("unaligned_addr", 32'h010, 32'h0, 1);
    check_bytes("unaligned", 64'h12345678, 4);

    mem[16] = 32'h00000001;
    ready_mode = 1;
    clear_logs();
    start_dump(9'h040, 1);
    wait_idle(200, 1'b0);
    check_bytes("toggle_ready", 64'h00000001, 4);
    chk("toggle_stalled", 32'(stall_seen > 0), 32'h1);

    ready_mode = 0;
    clear_logs();
    start_dump(9'h1FC, 2);
    wait_idle(200, 1'b0);
    check_addrs("wrap_addr", 32'h1FC, 32'h000, 2);

    clear_logs();
    start_dump(9'h040, 0);
    wait_idle(50, 1'b0);
    chk("zero_done_latency", done_cyc - start_cyc, 1);
    chk("zero_reads", got_addrs.size(), 0);
    chk("zero_valid", vld_seen, 0);

    disturb_second_byte(1'b0);
    disturb_second_byte(1'b1);

    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    clear_logs();
    start_dump(9'($urandom), 128);
    wait_idle(2000, 1'b1);
    chk("max_count_reads", got_addrs.size(), 128);

    for (int t = 0; t < 40; t++) begin
      int n;
      ready_mode = $urandom_range(0, 2);
      n = ($urandom % 10 == 0) ? $urandom_range(6, 40) : $urandom_range(0, 5);
      clear_logs();
      start_dump(9'($urandom), n);
      wait_idle(4000, 1'b1);
      chk("rand_bytes", got_bytes.size(), 4 * n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 Parameters SHALL be: NB_WIDTH, default 32, data word width; NB_ADDR, default 9, byte-address width of data memory; NB_BYTE, default 8, transmit byte width.
REQ-002 Ports SHALL be:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle request to begin a dump.
- i_abort  in  1  terminate the dump in progress.
- i_first_addr  in  NB_ADDR  starting byte address.
- i_word_count  in  NB_ADDR-1  number of words to dump, 0..128.
- o_mem_addr  out  NB_WIDTH  address presented to the MEM port.
- o_mem_read  out  1  load strobe to the MEM port.
- o_BHW  out  3  access size; constant 3'b011 (LW).
- i_read_data  in  NB_WIDTH  MEM load result; valid one cycle after o_mem_read.
- o_tx_data  out  NB_BYTE  byte to the UART transmitter.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  transmitter accepts the byte.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, SEND, DONE; o_busy SHALL be 1 in every state except IDLE.
REQ-004 IDLE: i_start=1 with i_word_count≠0 SHALL latch addr={i_first_addr[NB_ADDR-1:2],2'b00} and remaining=i_word_count, then go to REQ.
REQ-005 IDLE: i_start=1 with i_word_count=0 SHALL go directly to DONE; no memory or transmit activity occurs.
REQ-006 REQ, exactly one cycle: o_mem_read=1 and o_mem_addr=zero-extended addr; next state WAIT.
REQ-007 WAIT, exactly one cycle: the unit SHALL capture i_read_data into a 32-bit shift register at the closing edge, reset byte_idx to 0, and go to SEND.
REQ-008 SEND: o_tx_valid=1 and o_tx_data=shift[31:24], so each word goes out MSB byte first (big-endian).
REQ-009 On each o_tx_valid&i_tx_ready edge the unit SHALL shift left by 8 and increment byte_idx.
REQ-010 While o_tx_valid=1 and i_tx_ready=0, o_tx_data SHALL hold stable; o_tx_valid SHALL NOT drop before acceptance.
REQ-011 When the 4th byte is accepted: if remaining=1 the unit SHALL go to DONE; otherwise addr+=4 (modulo 2^NB_ADDR, wrapping 0x1FC->0x000), remaining-=1, and go to REQ.
REQ-012 DONE: o_done=1 for one cycle, then IDLE.
REQ-013 Minimum per-word latency SHALL be 6 cycles (REQ, WAIT, 4×SEND) with i_tx_ready held at 1.
REQ-014 i_start SHALL be ignored when not in IDLE.
REQ-015 i_abort SHALL force IDLE at the next edge from any state with no o_done pulse; it SHALL take priority over i_start.
REQ-016 o_mem_read and o_tx_valid SHALL be 0 in IDLE and DONE; o_mem_addr SHALL hold its last value outside REQ.
REQ-017 The unit SHALL never assert the MEM write strobe; it is read-only toward MEM.

Reset
REQ-018 Asserting i_reset SHALL immediately force: state=IDLE, o_mem_read=0, o_tx_valid=0, o_busy=0, o_done=0, o_mem_addr=0, o_tx_data=0, addr=0, remaining=0, byte_idx=0, shift register=0.
REQ-019 Reset mid-dump SHALL discard the partial word; no byte SHALL be re-presented after deassertion.

Structure
REQ-020 A shared package SHALL hold the state encoding, the BHW codes (SB=000, SH=001, SW/LW=011, LBU=100, LHU=101, LWU=111) and the bytes-per-word constant 4.
REQ-021 The byte serializer (shift register, byte_idx, valid/ready hold logic) SHALL be the sub-module mem_dump_serializer; the address/count FSM remains in the top level.

Verification
REQ-022 Bench memory: 0x10=0x12345678, 0x14=0xCAFEBABE. Start addr 0x10, count 2, ready=1 -> bytes 12,34,56,78,CA,FE,BA,BE; reads at 0x10 then 0x14; o_done exactly 12 cycles after the first REQ.
REQ-023 Start addr 0x13, count 1 -> address aligned to 0x10; bytes 12,34,56,78.
REQ-024 Ready toggles 0/1 every 2 cycles on a single word 0x00000001 -> bytes 00,00,00,01; o_tx_data stable while stalled; no byte lost or duplicated.
REQ-025 Start addr 0x1FC, count 2 -> reads at 0x1FC then 0x000.
REQ-026 Count 0 -> o_done one cycle later; o_mem_read and o_tx_valid never asserted.
REQ-027 Reset or i_abort asserted during the 2nd byte of a word -> IDLE with all outputs zero, no o_done; a following start at 0x10 count 1 -> 12,34,56,78.
